// File: rtl/picorv32_dv_pkg.sv
// rtl/picorv32_dv_pkg.sv - shared types, failure codes and defaults for the PicoRV32 test wrapper
package picorv32_dv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT       = 32'h8000_0000;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT    = 32'h8000_1000;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1_000_000;

    localparam logic [31:0] FAIL_TRAP    = 32'hBAD0_0001;
    localparam logic [31:0] FAIL_TIMEOUT = 32'hBAD0_0002;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } top_state_t;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_IFETCH,
        BR_DREQ,
        BR_RESP
    } br_state_t;

endpackage

// File: rtl/picorv32.sv
// rtl/picorv32.sv - compact RV32I-subset core (LUI, ADDI, JAL, LW, SW) on the picorv32 native memory port
// Ports: clk, resetn (sync, active low), trap, mem_valid/mem_instr/mem_ready,
//        mem_addr, mem_wdata, mem_wstrb, mem_rdata.
module picorv32 #(
    parameter bit          ENABLE_TRAP    = 1'b1,
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        trap,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] C_FETCH = 2'd0;
    localparam logic [1:0] C_EXEC  = 2'd1;
    localparam logic [1:0] C_MEM   = 2'd2;
    localparam logic [1:0] C_HALT  = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [1:0]  cstate;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_j;
    logic        legal;
    logic        rf_we;
    logic [31:0] rf_wdata;

    assign opcode  = insn[6:0];
    assign funct3  = insn[14:12];
    assign rd      = insn[11:7];
    assign rs1     = insn[19:15];
    assign rs2     = insn[24:20];
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i   = {{20{insn[31]}}, insn[31:20]};
    assign imm_s   = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_j   = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};

    assign legal = (opcode == OP_LUI) || (opcode == OP_JAL) ||
                   ((opcode == OP_IMM) && (funct3 == 3'b000)) ||
                   ((opcode == OP_LOAD || opcode == OP_STORE) && (funct3 == 3'b010));

    // Writeback happens either in EXEC (ALU/jump link) or when a load completes.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = 32'd0;
        if (resetn && cstate == C_EXEC) begin
            if (opcode == OP_LUI) begin
                rf_we    = 1'b1;
                rf_wdata = {insn[31:12], 12'd0};
            end else if (opcode == OP_IMM && funct3 == 3'b000) begin
                rf_we    = 1'b1;
                rf_wdata = rs1_val + imm_i;
            end else if (opcode == OP_JAL) begin
                rf_we    = 1'b1;
                rf_wdata = pc + 32'd4;
            end
        end else if (resetn && cstate == C_MEM && mem_ready && mem_wstrb == 4'd0) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && rd != 5'd0) begin
            regs[rd] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cstate    <= C_FETCH;
            pc        <= PROGADDR_RESET;
            insn      <= 32'd0;
            trap      <= 1'b0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
        end else begin
            case (cstate)
                C_FETCH: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b1;
                        mem_addr  <= pc;
                        mem_wstrb <= 4'd0;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_instr <= 1'b0;
                        insn      <= mem_rdata;
                        cstate    <= C_EXEC;
                    end
                end
                C_EXEC: begin
                    if (!legal && ENABLE_TRAP) begin
                        trap   <= 1'b1;
                        cstate <= C_HALT;
                    end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        mem_valid <= 1'b1;
                        mem_instr <= 1'b0;
                        mem_addr  <= (opcode == OP_LOAD) ? rs1_val + imm_i : rs1_val + imm_s;
                        mem_wdata <= rs2_val;
                        mem_wstrb <= (opcode == OP_STORE) ? 4'hF : 4'h0;
                        cstate    <= C_MEM;
                    end else begin
                        pc     <= (opcode == OP_JAL) ? pc + imm_j : pc + 32'd4;
                        cstate <= C_FETCH;
                    end
                end
                C_MEM: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'd0;
                        pc        <= pc + 32'd4;
                        cstate    <= C_FETCH;
                    end
                end
                default: cstate <= C_HALT;
            endcase
        end
    end

endmodule

// File: rtl/picorv32_mem_bridge.sv
// rtl/picorv32_mem_bridge.sv - native memory port to split imem/dmem bridge with tohost decode
// Ports: clk, rst_n (async, active low), run, core native port (mem_*),
//        tohost_hit/tohost_data to the wrapper, imem_* and dmem_* to test memory.
module picorv32_mem_bridge
    import picorv32_dv_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tohost_hit,
    output logic [31:0] tohost_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        imem_en,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        dmem_en,
    input  logic        dmem_ready
);

    br_state_t br_state;
    logic      rsp_instr;
    logic      is_tohost;

    assign is_tohost   = mem_valid && !mem_instr && (mem_wstrb != 4'd0) && (mem_addr == TOHOST_ADDR);
    assign tohost_hit  = run && (br_state == BR_IDLE) && is_tohost;
    assign tohost_data = mem_wdata;
    assign mem_ready   = (br_state == BR_RESP);
    assign mem_rdata   = rsp_instr ? imem_rdata : dmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_state   <= BR_IDLE;
            rsp_instr  <= 1'b0;
            imem_en    <= 1'b0;
            imem_addr  <= 32'd0;
            dmem_en    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
        end else if (!run && br_state != BR_RESP) begin
            // Core is held in reset: abandon any request and park the outputs at zero.
            // A pending RESP still completes so the tohost ack is not lost.
            br_state   <= BR_IDLE;
            rsp_instr  <= 1'b0;
            imem_en    <= 1'b0;
            imem_addr  <= 32'd0;
            dmem_en    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'd0;
        end else begin
            case (br_state)
                BR_IDLE: begin
                    if (mem_valid) begin
                        if (mem_instr) begin
                            imem_en   <= 1'b1;
                            imem_addr <= {mem_addr[31:2], 2'b00};
                            rsp_instr <= 1'b1;
                            br_state  <= BR_IFETCH;
                        end else if (is_tohost) begin
                            rsp_instr <= 1'b0;
                            br_state  <= BR_RESP;
                        end else begin
                            dmem_en    <= 1'b1;
                            dmem_addr  <= {mem_addr[31:2], 2'b00};
                            dmem_wdata <= mem_wdata;
                            dmem_wstrb <= mem_wstrb;
                            rsp_instr  <= 1'b0;
                            br_state   <= BR_DREQ;
                        end
                    end
                end
                BR_IFETCH: begin
                    imem_en  <= 1'b0;
                    br_state <= BR_RESP;
                end
                BR_DREQ: begin
                    if (dmem_ready) begin
                        dmem_en  <= 1'b0;
                        br_state <= BR_RESP;
                    end
                end
                default: br_state <= BR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/picorv32_dv_wrapper.sv
// rtl/picorv32_dv_wrapper.sv - start/done/pass test harness around a PicoRV32 core with split memories
// Ports: clk, reset (async, active low), test_start/test_done/test_pass/test_result,
//        imem_addr/imem_rdata/imem_en, dmem_addr/dmem_rdata/dmem_wdata/dmem_wstrb/dmem_en/dmem_ready.
module picorv32_dv_wrapper
    import picorv32_dv_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        test_start,
    output logic        test_done,
    output logic        test_pass,
    output logic [31:0] test_result,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        imem_en,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    output logic        dmem_en,
    input  logic        dmem_ready
);

    // Counter value seen during the last allowed run cycle.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    top_state_t  state;
    logic        run;
    logic        core_resetn;
    logic [31:0] timeout_cnt;

    logic        core_trap;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        tohost_hit;
    logic [31:0] tohost_data;

    assign run         = (state == ST_RUN);
    assign core_resetn = reset & run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            timeout_cnt <= 32'd0;
            test_done   <= 1'b0;
            test_pass   <= 1'b0;
            test_result <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Core reset is asserted throughout IDLE/DONE, so a restart from DONE
                    // always sees at least one reset cycle before RUN.
                    if (test_start) begin
                        state       <= ST_RUN;
                        timeout_cnt <= 32'd0;
                        test_done   <= 1'b0;
                        test_pass   <= 1'b0;
                        test_result <= 32'd0;
                    end
                end
                ST_RUN: begin
                    timeout_cnt <= timeout_cnt + 32'd1;
                    if (tohost_hit) begin
                        state       <= ST_DONE;
                        test_done   <= 1'b1;
                        test_pass   <= (tohost_data == 32'd1);
                        test_result <= tohost_data;
                    end else if (core_trap) begin
                        state       <= ST_DONE;
                        test_done   <= 1'b1;
                        test_pass   <= 1'b0;
                        test_result <= FAIL_TRAP;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state       <= ST_DONE;
                        test_done   <= 1'b1;
                        test_pass   <= 1'b0;
                        test_result <= FAIL_TIMEOUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    picorv32 #(
        .ENABLE_TRAP    (1'b1),
        .PROGADDR_RESET (RESET_PC)
    ) u_core (
        .clk       (clk),
        .resetn    (core_resetn),
        .trap      (core_trap),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    picorv32_mem_bridge #(
        .TOHOST_ADDR (TOHOST_ADDR)
    ) u_bridge (
        .clk         (clk),
        .rst_n       (reset),
        .run         (run),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .tohost_hit  (tohost_hit),
        .tohost_data (tohost_data),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_en     (imem_en),
        .dmem_addr   (dmem_addr),
        .dmem_rdata  (dmem_rdata),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_en     (dmem_en),
        .dmem_ready  (dmem_ready)
    );

endmodule

// File: tb/tb_picorv32_dv_wrapper.sv
// tb/tb_picorv32_dv_wrapper.sv - directed self-checking bench for picorv32_dv_wrapper
module tb_picorv32_dv_wrapper;

    localparam logic [31:0] TOHOST = 32'h8000_1000;

    localparam logic [31:0] I_LUI_T0  = 32'h800012B7; // lui  t0,0x80001
    localparam logic [31:0] I_LUI_T1  = 32'h80000337; // lui  t1,0x80000
    localparam logic [31:0] I_LI_A0_1 = 32'h00100513; // addi a0,x0,1
    localparam logic [31:0] I_LI_A0_7 = 32'h00700513; // addi a0,x0,7
    localparam logic [31:0] I_SW_A0   = 32'h00A2A023; // sw   a0,0(t0)
    localparam logic [31:0] I_LW_A0   = 32'h10032503; // lw   a0,0x100(t1)
    localparam logic [31:0] I_LOOP    = 32'h0000006F; // jal  x0,0

    logic        clk;
    logic        reset;
    logic        test_start;
    logic        test_done;
    logic        test_pass;
    logic [31:0] test_result;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_en;
    logic        dmem_ready = 1'b1;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    int          stall_req = 0;
    int          stall_used = 0;
    int          dmem_en_cycles = 0;
    int          tohost_fwd = 0;
    int          overlap_cnt = 0;
    bit          fetched = 0;
    logic [31:0] first_fetch_addr = 32'd0;
    logic [31:0] last_dmem_addr = 32'd0;

    picorv32_dv_wrapper #(
        .RESET_PC       (32'h8000_0000),
        .TOHOST_ADDR    (TOHOST),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .test_start  (test_start),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .test_result (test_result),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_en     (imem_en),
        .dmem_addr   (dmem_addr),
        .dmem_rdata  (dmem_rdata),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_en     (dmem_en),
        .dmem_ready  (dmem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:10] == 22'h200000) return mem[a[9:2]];
        return 32'd0;
    endfunction

    // Test memory: read-only, one-cycle latency on both ports.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_read(imem_addr);
        if (dmem_en && dmem_ready && dmem_wstrb == 4'd0) dmem_rdata <= mem_read(dmem_addr);
    end

    // Observation and dmem_ready stall generation, away from the active edge.
    always @(negedge clk) begin
        if (test_start) fetched = 1'b0;
        else if (imem_en && !fetched) begin
            fetched = 1'b1;
            first_fetch_addr = imem_addr;
        end
        if (imem_en && dmem_en) overlap_cnt++;
        if (dmem_en) begin
            dmem_en_cycles++;
            last_dmem_addr = dmem_addr;
        end
        if (dmem_en && dmem_addr == TOHOST) tohost_fwd++;
        if (dmem_en && stall_used < stall_req) begin
            stall_used++;
            dmem_ready = 1'b0;
        end else begin
            dmem_ready = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic run_test(input int limit, output int cycles, output bit seen);
        @(negedge clk) test_start = 1'b1;
        @(negedge clk) test_start = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (test_done) seen = 1'b1;
        end
    endtask

    int cyc;
    bit seen;
    int fwd0, den0;

    initial begin
        reset = 1'b0;
        test_start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, test_done}, 32'd0);
        check("rst_imem_en", {31'd0, imem_en}, 32'd0);
        check("rst_dmem_en", {31'd0, dmem_en}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_done", {31'd0, test_done}, 32'd0);
        check("idle_pass", {31'd0, test_pass}, 32'd0);
        check("idle_result", test_result, 32'd0);

        // Passing program: li a0,1 ; sw a0 -> tohost
        mem[0] = I_LUI_T0; mem[1] = I_LI_A0_1; mem[2] = I_SW_A0; mem[3] = I_LOOP;
        fwd0 = tohost_fwd;
        run_test(500, cyc, seen);
        check("pass_done", {31'd0, seen}, 32'd1);
        check("pass_pass", {31'd0, test_pass}, 32'd1);
        check("pass_result", test_result, 32'd1);
        check("pass_first_fetch", first_fetch_addr, 32'h8000_0000);
        check("pass_tohost_not_fwd", 32'(tohost_fwd - fwd0), 32'd0);
        repeat (5) @(negedge clk);
        check("pass_hold_done", {31'd0, test_done}, 32'd1);
        check("pass_hold_result", test_result, 32'd1);

        // Failing tohost value 7, restarted straight from DONE
        mem[1] = I_LI_A0_7;
        run_test(500, cyc, seen);
        check("res7_done", {31'd0, seen}, 32'd1);
        check("res7_pass", {31'd0, test_pass}, 32'd0);
        check("res7_result", test_result, 32'd7);

        // Illegal instruction at the reset vector
        clear_mem();
        run_test(500, cyc, seen);
        check("trap_done", {31'd0, seen}, 32'd1);
        check("trap_pass", {31'd0, test_pass}, 32'd0);
        check("trap_result", test_result, 32'hBAD0_0001);

        // Infinite loop: timeout after exactly 1000 run cycles
        mem[0] = I_LOOP;
        run_test(3000, cyc, seen);
        check("tmo_done", {31'd0, seen}, 32'd1);
        check("tmo_cycles", 32'(cyc), 32'd1000);
        check("tmo_pass", {31'd0, test_pass}, 32'd0);
        check("tmo_result", test_result, 32'hBAD0_0002);

        // Load with dmem_ready low for 5 cycles
        clear_mem();
        mem[0] = I_LUI_T0; mem[1] = I_LUI_T1; mem[2] = I_LW_A0; mem[3] = I_SW_A0; mem[4] = I_LOOP;
        mem[64] = 32'd1;
        den0 = dmem_en_cycles;
        stall_req = stall_used + 5;
        run_test(500, cyc, seen);
        check("ld_done", {31'd0, seen}, 32'd1);
        check("ld_en_cycles", 32'(dmem_en_cycles - den0), 32'd6);
        check("ld_addr", last_dmem_addr, 32'h8000_0100);
        check("ld_pass", {31'd0, test_pass}, 32'd1);
        check("ld_result", test_result, 32'd1);

        // Reset in the middle of a run, then restart
        mem[0] = I_LUI_T0; mem[1] = I_LI_A0_1; mem[2] = I_SW_A0; mem[3] = I_LOOP;
        @(negedge clk) test_start = 1'b1;
        @(negedge clk) test_start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_imem_en", {31'd0, imem_en}, 32'd0);
        check("mid_rst_imem_addr", imem_addr, 32'd0);
        check("mid_rst_dmem_en", {31'd0, dmem_en}, 32'd0);
        check("mid_rst_done", {31'd0, test_done}, 32'd0);
        check("mid_rst_result", test_result, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", {31'd0, test_done}, 32'd0);
        check("post_rst_imem_en", {31'd0, imem_en}, 32'd0);
        run_test(500, cyc, seen);
        check("rerun_first_fetch", first_fetch_addr, 32'h8000_0000);
        check("rerun_done", {31'd0, seen}, 32'd1);
        check("rerun_pass", {31'd0, test_pass}, 32'd1);
        check("rerun_result", test_result, 32'd1);

        check("no_imem_dmem_overlap", 32'(overlap_cnt), 32'd0);
        check("no_tohost_fwd_total", 32'(tohost_fwd), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
